// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, stage-record type and helpers for the pipelined CLA
//
// Purpose : common definitions for cla_pipe_adder and cla_block.
// Contents: default WIDTH/BLOCK, clog2 helper, and the per-stage control record.
//           The control record is width independent; the wide per-stage fields
//           (partial sum, remaining operands) live beside it in the top.

package cla_pkg;

    localparam int CLA_WIDTH = 16;
    localparam int CLA_BLOCK = 4;

    // Control portion of one pipeline stage record.
    //   valid : stage holds a live transaction
    //   carry : pending carry into the group this stage resolves
    //   a_msb : sign bit of operand a
    //   b_msb : sign bit of the effective operand b (inverted when subtracting)
    typedef struct packed {
        logic valid;
        logic carry;
        logic a_msb;
        logic b_msb;
    } cla_ctrl_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cla_block.sv
// rtl/cla_block.sv - combinational BLOCK-bit carry-lookahead group
//
// Purpose : resolves one lookahead group of the pipelined adder.
// Ports   : a, b  [BLOCK-1:0] group operand bits
//           cin               carry into the group's bit 0
//           s     [BLOCK-1:0] group sum bits
//           g, p              group generate / propagate
//           cout              carry out of the group's top bit

module cla_block
    import cla_pkg::*;
#(
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             g,
    output logic             p,
    output logic             cout
);

    always_comb begin
        logic carry;
        logic gen_i;
        logic prop_i;
        logic grp_g;
        logic grp_p;

        s     = '0;
        carry = cin;
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            gen_i  = a[i] & b[i];
            prop_i = a[i] ^ b[i];
            s[i]   = prop_i ^ carry;
            carry  = gen_i | (prop_i & carry);
            // Group terms fold upward from bit 0: the group generates if bit i
            // generates, or bit i propagates a carry generated below it.
            grp_g  = gen_i | (prop_i & grp_g);
            grp_p  = grp_p & prop_i;
        end
        g    = grp_g;
        p    = grp_p;
        cout = carry;
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder with valid/ready streaming
//
// Purpose : WIDTH-bit adder split into BLOCK-bit lookahead groups, one group
//           resolved per pipeline stage, carry registered between stages.
//           Bubble-collapsing handshake with full backpressure.
// Ports   : clk, rst_n (synchronous, active low)
//           in_valid / in_ready, a, b, carry_in      input stream
//           sub (only with CLA_PIPE_SUB_EN)          a + ~b + 1, carry_in ignored
//           out_valid / out_ready, sum, carry_out,
//           overflow                                 output stream
// Config  : define CLA_PIPE_SUB_EN to add the subtract control input.
// WIDTH must be a multiple of BLOCK.

module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef CLA_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STAGES = WIDTH / BLOCK;

    // Stage records: control bits plus wide partial-sum / operand fields.
    cla_ctrl_t        ctrl_q [STAGES];
    cla_ctrl_t        ctrl_d [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] a_d    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic [WIDTH-1:0] b_d    [STAGES];
    logic [WIDTH-1:0] psum_q [STAGES];
    logic [WIDTH-1:0] psum_d [STAGES];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    // go[k]: stage k's content may move forward this cycle.
    logic [STAGES-1:0] go;

    logic [BLOCK-1:0] blk_s    [STAGES];
    logic             blk_g    [STAGES];
    logic             blk_p    [STAGES];
    logic             blk_cout [STAGES];

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef CLA_PIPE_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : carry_in;
`else
    assign b_eff   = b;
    assign cin_eff = carry_in;
`endif

    // One lookahead group per stage; each sees only its own operand slice
    // and the carry registered by the stage before it.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_block #(
            .BLOCK (BLOCK)
        ) u_blk (
            .a    (a_q[k][k*BLOCK +: BLOCK]),
            .b    (b_q[k][k*BLOCK +: BLOCK]),
            .cin  (ctrl_q[k].carry),
            .s    (blk_s[k]),
            .g    (blk_g[k]),
            .p    (blk_p[k]),
            .cout (blk_cout[k])
        );
    end

    // Ready chain, combinational from out_ready back to in_ready.
    always_comb begin
        logic chain;
        go            = '0;
        chain         = !out_valid_q || out_ready;
        go[STAGES-1]  = chain;
        for (int k = STAGES - 2; k >= 0; k--) begin
            chain = !ctrl_q[k+1].valid || chain;
            go[k] = chain;
        end
    end

    assign in_ready = !ctrl_q[0].valid || go[0];

    always_comb begin
        logic [WIDTH-1:0] final_sum;

        ctrl_d      = ctrl_q;
        a_d         = a_q;
        b_d         = b_q;
        psum_d      = psum_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        // Stage 0 captures the input; sign bits are taken from the effective
        // operands so overflow follows ~b when subtracting.
        if (in_ready) begin
            ctrl_d[0].valid = in_valid;
            if (in_valid) begin
                a_d[0]          = a;
                b_d[0]          = b_eff;
                psum_d[0]       = '0;
                ctrl_d[0].carry = cin_eff;
                ctrl_d[0].a_msb = a[WIDTH-1];
                ctrl_d[0].b_msb = b_eff[WIDTH-1];
            end
        end

        // Intermediate groups: carry into the next stage uses the group G/P.
        for (int k = 1; k < STAGES; k++) begin
            if (go[k-1]) begin
                ctrl_d[k].valid = ctrl_q[k-1].valid;
                if (ctrl_q[k-1].valid) begin
                    a_d[k]                           = a_q[k-1];
                    b_d[k]                           = b_q[k-1];
                    psum_d[k]                        = psum_q[k-1];
                    psum_d[k][(k-1)*BLOCK +: BLOCK]  = blk_s[k-1];
                    ctrl_d[k].carry = blk_g[k-1] | (blk_p[k-1] & ctrl_q[k-1].carry);
                    ctrl_d[k].a_msb = ctrl_q[k-1].a_msb;
                    ctrl_d[k].b_msb = ctrl_q[k-1].b_msb;
                end
            end
        end

        // Last group completes the sum; its carry out is the adder carry out.
        final_sum                               = psum_q[STAGES-1];
        final_sum[(STAGES-1)*BLOCK +: BLOCK]    = blk_s[STAGES-1];

        // Output registers only load when not stalled, which keeps
        // sum/carry_out/overflow stable while out_valid && !out_ready.
        if (go[STAGES-1]) begin
            out_valid_d = ctrl_q[STAGES-1].valid;
            if (ctrl_q[STAGES-1].valid) begin
                sum_d       = final_sum;
                carry_out_d = blk_cout[STAGES-1];
                overflow_d  = (ctrl_q[STAGES-1].a_msb == ctrl_q[STAGES-1].b_msb) &&
                              (final_sum[WIDTH-1] != ctrl_q[STAGES-1].a_msb);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            a_q         <= a_d;
            b_q         <= b_d;
            psum_q      <= psum_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder (WIDTH=16, BLOCK=4)

module tb_cla_pipe_adder;

    localparam int WIDTH  = 16;
    localparam int BLOCK  = 4;
    localparam int STAGES = WIDTH / BLOCK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub_v;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    always #5 clk = ~clk;

    cla_pipe_adder #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef CLA_PIPE_SUB_EN
        .sub       (sub_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             o;
        int               acc_cyc;
    } exp_t;

    exp_t             q[$];
    int               checks   = 0;
    int               failures = 0;
    int               cyc      = 0;
    int               n_out    = 0;
    logic             got_out;
    logic [WIDTH-1:0] got_sum;
    logic             got_c;
    logic             got_o;
    int               got_lat;
    logic             held_valid = 1'b0;
    logic [WIDTH+1:0] held;

    // Reference: plain integer addition on the effective operands.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic sb);
        exp_t             r;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] y_eff;
        logic             c_eff;
        y_eff     = sb ? ~y : y;
        c_eff     = sb ? 1'b1 : ci;
        full      = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, c_eff};
        r.sum     = full[WIDTH-1:0];
        r.c       = full[WIDTH];
        r.o       = (x[WIDTH-1] == y_eff[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        r.acc_cyc = 0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: observe handshakes at the falling edge, then advance.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            // Five slots (4 stages + output); only a full, stalled pipe refuses input.
            check("in_ready", {31'b0, in_ready}, {31'b0, out_ready || (q.size() < STAGES + 1)});
            if (held_valid) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_data", {14'b0, sum, carry_out, overflow}, {14'b0, held});
            end
            held_valid = out_valid && !out_ready;
            held       = {sum, carry_out, overflow};
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    check("unexpected_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sum", {16'b0, sum}, {16'b0, e.sum});
                    check("carry_out", {31'b0, carry_out}, {31'b0, e.c});
                    check("overflow", {31'b0, overflow}, {31'b0, e.o});
                    got_out = 1'b1;
                    got_sum = sum;
                    got_c   = carry_out;
                    got_o   = overflow;
                    // Edges from the accepting edge to the edge that raised out_valid.
                    got_lat = cyc - e.acc_cyc - 1;
                end
            end
            if (in_valid && in_ready) begin
                e         = model(a, b, carry_in, sub_v);
                e.acc_cyc = cyc;
                q.push_back(e);
            end
        end else begin
            q.delete();
            held_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_one(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic ci, input logic sb, input logic [WIDTH-1:0] exp_sum,
                           input logic exp_c, input logic exp_o);
        a        = x;
        b        = y;
        carry_in = ci;
        sub_v    = sb;
        in_valid = 1'b1;
        got_out  = 1'b0;
        got_lat  = -1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 12 && !got_out; i++) tick();
        check({tag, "_done"}, {31'b0, got_out}, 32'd1);
        check({tag, "_sum"}, {16'b0, got_sum}, {16'b0, exp_sum});
        check({tag, "_cout"}, {31'b0, got_c}, {31'b0, exp_c});
        check({tag, "_ovf"}, {31'b0, got_o}, {31'b0, exp_o});
        check({tag, "_latency"}, got_lat, STAGES);
        sub_v = 1'b0;
    endtask

    initial begin
        int   sent;
        int   t;
        int   n_before;
        logic acc;
        logic saw_bp;
        exp_t e;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        sub_v     = 1'b0;
        out_ready = 1'b1;
        got_out   = 1'b0;
        got_sum   = '0;
        got_c     = 1'b0;
        got_o     = 1'b0;
        got_lat   = -1;
        repeat (2) tick();
        rst_n = 1'b1;

        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_sum", {16'b0, sum}, 32'd0);
        check("reset_carry_out", {31'b0, carry_out}, 32'd0);
        check("reset_overflow", {31'b0, overflow}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);

        run_one("add_small", 16'h0002, 16'h0004, 1'b1, 1'b0, 16'h0007, 1'b0, 1'b0);
        run_one("ripple_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Back-to-back random stream with a three-cycle output stall.
        n_before = n_out;
        sent     = 0;
        t        = 0;
        saw_bp   = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        carry_in = 1'($urandom_range(0, 1));
        while ((sent < 10 || q.size() > 0) && t < 60) begin
            out_ready = !(t >= 5 && t <= 7);
            in_valid  = (sent < 10);
            acc       = in_valid && in_ready;
            if (in_valid && !in_ready) saw_bp = 1'b1;
            tick();
            if (acc) begin
                sent++;
                a        = 16'($urandom);
                b        = 16'($urandom);
                carry_in = 1'($urandom_range(0, 1));
            end
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", sent, 10);
        check("stream_results", n_out - n_before, 10);
        check("stream_drained", q.size(), 0);
        check("stream_backpressure", {31'b0, saw_bp}, 32'd1);

        // Reset with transactions in flight: nothing may emerge afterwards.
        n_before = n_out;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            carry_in = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (8) tick();
        check("rst_no_stale", n_out - n_before, 0);

        e = model(16'h1234, 16'hEDCC, 1'b0, 1'b0);
        run_one("post_reset", 16'h1234, 16'hEDCC, 1'b0, 1'b0, e.sum, e.c, e.o);

`ifdef CLA_PIPE_SUB_EN
        run_one("sub_3_5", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
